mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates one shared single-port instruction/data memory between two requesters.
- Requester 0 is the multicycle CPU memory port. Requester 1 is the loader/DMA port that fills memory before and during execution.
- Grants one whole transaction at a time and sequences the memory through issue and fixed-latency wait.
- Returns a one-cycle done pulse and read data to the owning requester.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- LAT, 1, memory read latency in cycles from the mem_en cycle to mem_rdata valid. Legal values are 1 to 15.
- FIXED_PRIO, 0, 0 selects round-robin arbitration; 1 selects fixed priority with CPU always winning.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; state is reset when reset==0 at a rising edge.
- cpu_req  in  1  CPU transaction request.
- cpu_we  in  1  CPU write enable; 0 is a read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  CPU request accepted; one-cycle pulse.
- cpu_done  out  1  CPU transaction complete; one-cycle pulse.
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_done  same as the CPU group, for requester 1.
- rdata  out  DW  read data of the last completed read; valid when either done is high.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe; only ever high together with mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- States and transitions: IDLE -> ISSUE -> WAIT (LAT cycles) -> DONE -> IDLE.
- IDLE:
  - If no req is high, stay in IDLE.
  - Otherwise choose a winner and capture its we, addr and wdata into internal registers. Set owner to the winner and go to ISSUE.
- ISSUE (1 cycle):
  - mem_en=1; mem_we=captured we.
  - The winner's gnt=1 in this cycle only.
  - Load the wait counter with LAT-1 and go to WAIT.
- WAIT (LAT cycles):
  - Decrement the counter each cycle.
  - In the cycle the counter is 0, register mem_rdata into rdata (reads only; writes leave rdata unchanged) and go to DONE.
- DONE (1 cycle):
  - owner's done=1; go to IDLE.
  - req inputs are ignored in ISSUE, WAIT and DONE.
- mem_addr and mem_wdata are driven from the captured registers in every state. They are held stable from ISSUE through DONE.
- Latency: a request first seen in IDLE at cycle c gives gnt at c+1 and done at c+LAT+2. The next request can be accepted in IDLE at c+LAT+3.
- Requester rule: fields must be stable while req is high in IDLE.
  - Dropping req in the cycle after done means no reissue.
  - Keeping req high in the cycle after done means a new transaction.
- Arbitration:
  - FIXED_PRIO=1: CPU wins whenever cpu_req=1.
  - FIXED_PRIO=0: a last-owner pointer is updated at each grant. When both requests are high, the requester that is not the last owner wins. A single request always wins.
  - The pointer resets to "DMA last", so the CPU wins the first tie.
- Reset values: state=IDLE, pointer=DMA, counter=0. All outputs are 0: gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy.
- Reset mid-transaction returns to IDLE on the same edge. The in-flight access is discarded: no done and no further mem_en. rdata clears to 0.
- Exactly one of cpu_gnt/dma_gnt may be high in any cycle; the same holds for cpu_done/dma_done. No gnt or done is ever issued without a matching req having been seen in IDLE.
- Illegal state encodings recover to IDLE with all strobes 0.

Test Plan:
- CPU read, LAT=2: mem_rdata=0xDEADBEEF. cpu_req high at cycle 0 with addr 0x40, we=0, then dropped after done -> cpu_gnt at cycle 1, mem_en=1/mem_we=0/mem_addr=0x40 at cycle 1, cpu_done and rdata=0xDEADBEEF at cycle 4, busy low at cycle 5, no second mem_en.
- DMA write, LAT=1: addr 0x10, wdata 0x12345678 -> mem_en=mem_we=1 with those values for exactly 1 cycle, dma_done at cycle 3, rdata unchanged from its previous value.
- Round-robin: both req held high for 4 transactions -> grant order CPU, DMA, CPU, DMA; never both gnt in one cycle. With FIXED_PRIO=1 -> CPU, CPU, CPU, CPU.
- Back-to-back: cpu_req held high across done, LAT=1 -> second cpu_gnt exactly 4 cycles after the first.
- Reset mid-WAIT: reset=0 during a WAIT cycle with LAT=3 -> next cycle busy=0, all outputs 0, no cpu_done. After reset=1 and both req high, the CPU is granted first.
- Idle: no req for 20 cycles -> mem_en, gnt, done and busy stay 0 throughout.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a shared single-port memory.
// Serves one whole transaction at a time through issue and fixed-latency wait.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LAT        = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_done,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t        state;
  state_t        state_nxt;
  logic          last_dma;
  logic          owner;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [3:0]    cnt;
  logic          any_req;
  logic          pick_dma;

  assign any_req = cpu_req | dma_req;

  // On a tie the requester that did not own the last grant wins.
  generate
    if (FIXED_PRIO != 0) begin : g_fixed
      assign pick_dma = ~cpu_req;
    end else begin : g_rr
      assign pick_dma = dma_req & (~cpu_req | ~last_dma);
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      last_dma <= 1'b1;
      owner    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt      <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= pick_dma;
            last_dma <= pick_dma;
            we_q     <= pick_dma ? dma_we    : cpu_we;
            addr_q   <= pick_dma ? dma_addr  : cpu_addr;
            wdata_q  <= pick_dma ? dma_wdata : cpu_wdata;
          end
        end
        ISSUE: cnt <= CNT_INIT;
        WAIT: begin
          if (cnt == 4'd0) begin
            if (!we_q) rdata_q <= mem_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    cpu_gnt  = 1'b0;
    dma_gnt  = 1'b0;
    cpu_done = 1'b0;
    dma_done = 1'b0;
    unique case (state)
      ISSUE: begin
        mem_en  = 1'b1;
        mem_we  = we_q;
        cpu_gnt = ~owner;
        dma_gnt = owner;
      end
      DONE: begin
        cpu_done = ~owner;
        dma_done = owner;
      end
      default: ;
    endcase
  end

  assign busy      = (state != IDLE);
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter over four parameter sets:
// 0: LAT=1 rr, 1: LAT=2 rr, 2: LAT=3 rr, 3: LAT=1 fixed priority.
module tb_mem_arbiter;
  localparam int N = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [N];
  logic        cpu_req   [N];
  logic        cpu_we    [N];
  logic [31:0] cpu_addr  [N];
  logic [31:0] cpu_wdata [N];
  logic        cpu_gnt   [N];
  logic        cpu_done  [N];
  logic        dma_req   [N];
  logic        dma_we    [N];
  logic [31:0] dma_addr  [N];
  logic [31:0] dma_wdata [N];
  logic        dma_gnt   [N];
  logic        dma_done  [N];
  logic [31:0] rdata     [N];
  logic        mem_en    [N];
  logic        mem_we    [N];
  logic [31:0] mem_addr  [N];
  logic [31:0] mem_wdata [N];
  logic [31:0] mem_rdata [N];
  logic        busy      [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_arbiter #(
      .AW(32),
      .DW(32),
      .LAT(g == 2 ? 3 : (g == 1 ? 2 : 1)),
      .FIXED_PRIO(g == 3 ? 1 : 0)
    ) u_dut (
      .clk(clk),
      .reset(rst[g]),
      .cpu_req(cpu_req[g]),
      .cpu_we(cpu_we[g]),
      .cpu_addr(cpu_addr[g]),
      .cpu_wdata(cpu_wdata[g]),
      .cpu_gnt(cpu_gnt[g]),
      .cpu_done(cpu_done[g]),
      .dma_req(dma_req[g]),
      .dma_we(dma_we[g]),
      .dma_addr(dma_addr[g]),
      .dma_wdata(dma_wdata[g]),
      .dma_gnt(dma_gnt[g]),
      .dma_done(dma_done[g]),
      .rdata(rdata[g]),
      .mem_en(mem_en[g]),
      .mem_we(mem_we[g]),
      .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .busy(busy[g])
    );
  end

  int tests = 0;
  int fails = 0;
  int ord[4];
  int ng;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] strobes(input int i);
    return {mem_en[i], cpu_gnt[i], dma_gnt[i],
            cpu_done[i], dma_done[i], busy[i]};
  endfunction

  // Collect grant order (0=cpu, 1=dma) within a cycle budget.
  task automatic grants(input int i, input int want,
                        input int budget);
    ng = 0;
    for (int c = 0; c < budget && ng < want; c++) begin
      tick();
      chk("gnt_excl", 64'(cpu_gnt[i] & dma_gnt[i]), 0);
      if (cpu_gnt[i]) begin
        ord[ng] = 0;
        ng++;
      end else if (dma_gnt[i]) begin
        ord[ng] = 1;
        ng++;
      end
    end
    chk("grant_count", 64'(ng), 64'(want));
  endtask

  initial begin
    int first_g;
    int second_g;
    int nb;

    for (int i = 0; i < N; i++) begin
      rst[i]       = 1'b0;
      cpu_req[i]   = 1'b0;
      cpu_we[i]    = 1'b0;
      cpu_addr[i]  = '0;
      cpu_wdata[i] = '0;
      dma_req[i]   = 1'b0;
      dma_we[i]    = 1'b0;
      dma_addr[i]  = '0;
      dma_wdata[i] = '0;
      mem_rdata[i] = '0;
    end
    tick();
    tick();

    chk("rst_strobes", 64'(strobes(1)), 0);
    chk("rst_rdata", 64'(rdata[1]), 0);
    chk("rst_addr", 64'(mem_addr[1]), 0);
    chk("rst_wdata", 64'(mem_wdata[1]), 0);
    chk("rst_we", 64'(mem_we[1]), 0);
    for (int i = 0; i < N; i++) rst[i] = 1'b1;

    // CPU read, LAT=2
    mem_rdata[1] = 32'hDEAD_BEEF;
    cpu_addr[1]  = 32'h40;
    cpu_req[1]   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t1_gnt", 64'(cpu_gnt[1]), 64'(k == 1));
      chk("t1_men", 64'(mem_en[1]), 64'(k == 1));
      chk("t1_done", 64'(cpu_done[1]), 64'(k == 4));
      chk("t1_busy", 64'(busy[1]), 64'(k >= 1 && k <= 4));
      chk("t1_dgnt", 64'(dma_gnt[1]), 0);
      if (k == 1) begin
        chk("t1_mwe", 64'(mem_we[1]), 0);
        chk("t1_addr", 64'(mem_addr[1]), 64'h40);
      end
      if (k == 4) begin
        chk("t1_rdata", 64'(rdata[1]), 64'hDEAD_BEEF);
        cpu_req[1] = 1'b0;
      end
    end

    // Idle for 20 cycles
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("idle", 64'(strobes(1)), 0);
    end

    // CPU read then DMA write, LAT=1
    mem_rdata[0] = 32'hCAFE_F00D;
    cpu_addr[0]  = 32'h20;
    cpu_req[0]   = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t2r_gnt", 64'(cpu_gnt[0]), 64'(k == 1));
      chk("t2r_done", 64'(cpu_done[0]), 64'(k == 3));
      if (k == 3) begin
        chk("t2r_rdata", 64'(rdata[0]), 64'hCAFE_F00D);
        cpu_req[0] = 1'b0;
      end
    end
    mem_rdata[0] = 32'h5555_5555;
    dma_we[0]    = 1'b1;
    dma_addr[0]  = 32'h10;
    dma_wdata[0] = 32'h1234_5678;
    dma_req[0]   = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t2w_men", 64'(mem_en[0]), 64'(k == 1));
      chk("t2w_mwe", 64'(mem_we[0]), 64'(k == 1));
      chk("t2w_gnt", 64'(dma_gnt[0]), 64'(k == 1));
      chk("t2w_done", 64'(dma_done[0]), 64'(k == 3));
      chk("t2w_cdone", 64'(cpu_done[0]), 0);
      if (k <= 3) begin
        chk("t2w_addr", 64'(mem_addr[0]), 64'h10);
        chk("t2w_wdata", 64'(mem_wdata[0]), 64'h1234_5678);
      end
      if (k == 3) begin
        chk("t2w_rdata", 64'(rdata[0]), 64'hCAFE_F00D);
        dma_req[0] = 1'b0;
      end
    end

    // Back-to-back CPU, LAT=1
    dma_we[0]  = 1'b0;
    cpu_req[0] = 1'b1;
    first_g    = -1;
    second_g   = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (cpu_gnt[0]) begin
        if (first_g < 0) first_g = k;
        else if (second_g < 0) second_g = k;
      end
      if (k == 10) cpu_req[0] = 1'b0;
    end
    chk("b2b_first", 64'(first_g), 1);
    chk("b2b_second", 64'(second_g), 5);

    // LAT=3: full read, then reset mid-WAIT
    mem_rdata[2] = 32'hA5A5_A5A5;
    cpu_addr[2]  = 32'h80;
    cpu_req[2]   = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t3_gnt", 64'(cpu_gnt[2]), 64'(k == 1));
      chk("t3_done", 64'(cpu_done[2]), 64'(k == 5));
      chk("t3_busy", 64'(busy[2]), 64'(k >= 1 && k <= 5));
      if (k == 5) begin
        chk("t3_rdata", 64'(rdata[2]), 64'hA5A5_A5A5);
        cpu_req[2] = 1'b0;
      end
    end
    cpu_addr[2] = 32'h84;
    cpu_req[2]  = 1'b1;
    tick();
    chk("t4_gnt", 64'(cpu_gnt[2]), 1);
    tick();
    chk("t4_wait", 64'(busy[2] & ~mem_en[2]), 1);
    rst[2]     = 1'b0;
    cpu_req[2] = 1'b0;
    tick();
    chk("t4_strobes", 64'(strobes(2)), 0);
    chk("t4_rdata", 64'(rdata[2]), 0);
    chk("t4_addr", 64'(mem_addr[2]), 0);
    chk("t4_wdata", 64'(mem_wdata[2]), 0);
    chk("t4_mwe", 64'(mem_we[2]), 0);
    rst[2] = 1'b1;
    nb = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (strobes(2) != 6'd0) nb++;
    end
    chk("t4_quiet", 64'(nb), 0);

    // Round-robin after reset: CPU wins first tie
    cpu_addr[2] = 32'h88;
    dma_addr[2] = 32'h90;
    cpu_req[2]  = 1'b1;
    dma_req[2]  = 1'b1;
    grants(2, 4, 60);
    cpu_req[2] = 1'b0;
    dma_req[2] = 1'b0;
    chk("rr_0", 64'(ord[0]), 0);
    chk("rr_1", 64'(ord[1]), 1);
    chk("rr_2", 64'(ord[2]), 0);
    chk("rr_3", 64'(ord[3]), 1);

    // Fixed priority: CPU always wins
    cpu_req[3] = 1'b1;
    dma_req[3] = 1'b1;
    grants(3, 4, 40);
    cpu_req[3] = 1'b0;
    dma_req[3] = 1'b0;
    chk("fp_0", 64'(ord[0]), 0);
    chk("fp_1", 64'(ord[1]), 0);
    chk("fp_2", 64'(ord[2]), 0);
    chk("fp_3", 64'(ord[3]), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
